// File: rtl/vga_scan_reader.sv
// vga_scan_reader: VGA raster timing generator that fetches one framebuffer pixel per active position
// and presents sync, data-enable and colour aligned to the fixed memory read latency.
module vga_scan_reader #(
    parameter int          H_ACTIVE  = 640,
    parameter int          H_FP      = 16,
    parameter int          H_SYNC    = 96,
    parameter int          H_BP      = 48,
    parameter int          V_ACTIVE  = 480,
    parameter int          V_FP      = 10,
    parameter int          V_SYNC    = 2,
    parameter int          V_BP      = 33,
    parameter bit          SYNC_POL  = 1'b0,
    parameter int          RD_LAT    = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_enable,
    output logic        o_rdEn,
    output logic [31:0] o_rdAddr,
    input  logic [31:0] i_rdData,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_de,
    output logic [3:0]  o_red,
    output logic [3:0]  o_green,
    output logic [3:0]  o_blue,
    output logic        o_frameStart
);
    localparam logic [15:0] H_ACT  = 16'(H_ACTIVE);
    localparam logic [15:0] H_SS   = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] H_SE   = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] H_LAST = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [15:0] V_ACT  = 16'(V_ACTIVE);
    localparam logic [15:0] V_SS   = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] V_SE   = 16'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [15:0] V_LAST = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    // stage bits: [3]=frame start, [2]=vsync, [1]=hsync, [0]=active
    localparam logic [3:0]  IDLE   = {1'b0, ~SYNC_POL, ~SYNC_POL, 1'b0};

    logic                  running;
    logic [15:0]           hcnt, vcnt, hNext, vNext;
    logic                  hWrap;
    logic [3:0]            nextStage;
    logic [RD_LAT:0][3:0]  pipe;
    logic [3:0]            outStage;
    logic                  unusedBits;

    assign unusedBits = ^i_rdData[31:12];
    assign o_rdEn     = pipe[0][0];
    assign outStage   = pipe[RD_LAT];

    // The position is computed one clock ahead so the registered read strobe and
    // address line up with the counter value they belong to.
    always_comb begin
        hWrap     = hcnt == H_LAST;
        hNext     = (!running || hWrap) ? 16'd0 : hcnt + 16'd1;
        vNext     = !running ? 16'd0 : !hWrap ? vcnt : (vcnt == V_LAST) ? 16'd0 : vcnt + 16'd1;
        nextStage = {hNext == 16'd0 && vNext == 16'd0,
                     (vNext >= V_SS && vNext < V_SE) ? SYNC_POL : ~SYNC_POL,
                     (hNext >= H_SS && hNext < H_SE) ? SYNC_POL : ~SYNC_POL,
                     hNext < H_ACT && vNext < V_ACT};
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            running      <= 1'b0;
            hcnt         <= 16'd0;
            vcnt         <= 16'd0;
            o_rdAddr     <= BASE_ADDR;
            pipe         <= {(RD_LAT + 1){IDLE}};
            o_de         <= 1'b0;
            o_hsync      <= ~SYNC_POL;
            o_vsync      <= ~SYNC_POL;
            o_frameStart <= 1'b0;
            {o_red, o_green, o_blue} <= 12'h0;
        end else begin
            running      <= i_enable;
            hcnt         <= i_enable ? hNext : 16'd0;
            vcnt         <= i_enable ? vNext : 16'd0;
            o_rdAddr     <= (!i_enable || nextStage[3]) ? BASE_ADDR : o_rdEn ? o_rdAddr + 32'd4 : o_rdAddr;
            pipe         <= i_enable ? {pipe[RD_LAT-1:0], nextStage} : {(RD_LAT + 1){IDLE}};
            o_de         <= i_enable && outStage[0];
            o_hsync      <= i_enable ? outStage[1] : ~SYNC_POL;
            o_vsync      <= i_enable ? outStage[2] : ~SYNC_POL;
            o_frameStart <= i_enable && outStage[3];
            {o_red, o_green, o_blue} <= (i_enable && outStage[0]) ? i_rdData[11:0] : 12'h0;
        end
    end
endmodule

// File: tb/tb_vga_scan_reader.sv
// tb_vga_scan_reader: directed checks of raster timing, read addressing, latency alignment,
// blanking, async reset and enable restart on a small 8x6 raster with a data=addr memory.
module tb_vga_scan_reader;
    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        enable = 1'b1;
    logic        rdEn;
    logic [31:0] rdAddr;
    logic [31:0] rdData;
    logic        hsync, vsync, de, frameStart;
    logic [3:0]  red, green, blue;
    logic [31:0] mem1 = 32'hFFF, mem2 = 32'hFFF;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    vga_scan_reader #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b0), .RD_LAT(2), .BASE_ADDR(32'h100)
    ) dut (
        .i_clk(clk), .i_reset_n(rstN), .i_enable(enable),
        .o_rdEn(rdEn), .o_rdAddr(rdAddr), .i_rdData(rdData),
        .o_hsync(hsync), .o_vsync(vsync), .o_de(de),
        .o_red(red), .o_green(green), .o_blue(blue),
        .o_frameStart(frameStart)
    );

    // Two-clock memory returning its own address; idle slots return 0xFFF to expose blanking faults.
    always @(posedge clk) begin
        mem1 <= rdEn ? rdAddr : 32'hFFF;
        mem2 <= mem1;
    end
    assign rdData = mem2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic checkIdle(input string tag);
        check({tag, "_rd"}, {31'h0, rdEn}, 32'h0);
        check({tag, "_addr"}, rdAddr, 32'h100);
        check({tag, "_out"}, {16'h0, de, hsync, vsync, frameStart, red, green, blue}, {16'h0, 4'b0110, 12'h0});
    endtask

    // Scan starts at (0,0) on the first edge of the loop; position k=n-1 is read at cycle n
    // and appears on the outputs three cycles later.
    task automatic runScan(input string tag, input int cycles);
        int k, h, v, ko, ho, vo, a;
        logic act, deE, hsE, vsE, fsE;
        logic [11:0] colE;
        for (int n = 1; n <= cycles; n++) begin
            @(posedge clk);
            @(negedge clk);
            k = n - 1; h = k % 8; v = (k / 8) % 6;
            act = h < 4 && v < 3;
            check($sformatf("%s_rd%0d", tag, n), {31'h0, rdEn}, {31'h0, act});
            if (act) check($sformatf("%s_addr%0d", tag, n), rdAddr, 32'h100 + 32'(4 * (v * 4 + h)));
            ko = n - 4;
            if (ko < 0) begin
                deE = 0; hsE = 1; vsE = 1; fsE = 0; colE = 12'h0;
            end else begin
                ho = ko % 8; vo = (ko / 8) % 6;
                a = 'h100 + 4 * (vo * 4 + ho);
                deE = ho < 4 && vo < 3;
                hsE = !(ho == 5 || ho == 6);
                vsE = vo != 4;
                fsE = ko % 48 == 0;
                colE = deE ? 12'(a & 'hFFF) : 12'h0;
            end
            check($sformatf("%s_out%0d", tag, n), {16'h0, de, hsync, vsync, frameStart, red, green, blue},
                  {16'h0, deE, hsE, vsE, fsE, colE});
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        checkIdle("reset");
        rstN = 1'b1;
        runScan("scan", 110);
        runScan("cont", 0);
        rstN = 1'b1;
        check("fs_first_pos", 32'(frameStart), 32'h0);

        // Restart and hit a mid-line async reset while pixels are being shown.
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        runScan("pre", 20);
        check("pre_de", {31'h0, de}, 32'h1);
        rstN = 1'b0;
        #1;
        checkIdle("async");
        @(negedge clk);
        rstN = 1'b1;
        runScan("post", 20);

        // Drop enable mid-frame for 10 clocks, then restart from (0,0).
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkIdle($sformatf("dis%0d", i));
        end
        enable = 1'b1;
        runScan("ren", 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
